// File: rtl/n8_pad_responder.sv
// Responder end of the N8 serial pad link: snapshots buttons on latch, shifts one bit per pulse.
// Optional A/B autofire is built when N8_RESP_TURBO_EN is defined.
module n8_pad_responder #(
  parameter int   ACTIVE_LOW   = 1,
  parameter logic TAIL_LEVEL   = 1'b1,
  parameter int   TURBO_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       latch_in,
  input  logic       pulse_in,
  input  logic [7:0] buttons,
  output logic       data_out,
  output logic [3:0] bit_idx,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, TAIL} state_t;

  state_t     r_state;
  logic [7:0] r_shift;
  logic       r_latch_s1, r_latch_s2, r_latch_h;
  logic       r_pulse_s1, r_pulse_s2, r_pulse_h;
  logic       w_latch_rise, w_latch_fall, w_pulse_rise;
  logic [7:0] w_gated;

  function automatic logic enc(input logic b);
    return (ACTIVE_LOW != 0) ? ~b : b;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_latch_s1 <= 1'b0;
      r_latch_s2 <= 1'b0;
      r_latch_h  <= 1'b0;
      r_pulse_s1 <= 1'b0;
      r_pulse_s2 <= 1'b0;
      r_pulse_h  <= 1'b0;
    end else begin
      r_latch_s1 <= latch_in;
      r_latch_s2 <= r_latch_s1;
      r_latch_h  <= r_latch_s2;
      r_pulse_s1 <= pulse_in;
      r_pulse_s2 <= r_pulse_s1;
      r_pulse_h  <= r_pulse_s2;
    end
  end

  assign w_latch_rise = r_latch_s2 & ~r_latch_h;
  assign w_latch_fall = ~r_latch_s2 & r_latch_h;
  assign w_pulse_rise = r_pulse_s2 & ~r_pulse_h;

`ifdef N8_RESP_TURBO_EN
  logic [3:0] r_turbo_cnt;
  logic       r_turbo_phase;

  // Phase flips every TURBO_FRAMES completed frames; A/B are released while it is 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_turbo_cnt   <= 4'd0;
      r_turbo_phase <= 1'b0;
    end else if (frame_done) begin
      if (r_turbo_cnt == 4'(TURBO_FRAMES - 1)) begin
        r_turbo_cnt   <= 4'd0;
        r_turbo_phase <= ~r_turbo_phase;
      end else begin
        r_turbo_cnt <= r_turbo_cnt + 4'd1;
      end
    end
  end

  assign w_gated = {buttons[7:2], buttons[1:0] & {2{r_turbo_phase}}};
`else
  logic w_unused_turbo;
  assign w_unused_turbo = (TURBO_FRAMES > 0);
  assign w_gated        = buttons;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= 8'd0;
      data_out   <= enc(1'b0);
      bit_idx    <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A latch rise aborts whatever is in progress and outranks a coincident pulse.
      if (w_latch_rise) begin
        r_state  <= LOAD;
        r_shift  <= w_gated;
        data_out <= enc(w_gated[0]);
        bit_idx  <= 4'd0;
      end else begin
        case (r_state)
          IDLE: begin
            data_out <= enc(1'b0);
            bit_idx  <= 4'd0;
          end
          LOAD: begin
            if (w_latch_fall) begin
              r_state    <= SHIFT;
              frame_done <= 1'b1;
            end else begin
              r_shift  <= w_gated;
              data_out <= enc(w_gated[0]);
              bit_idx  <= 4'd0;
            end
          end
          SHIFT: begin
            if (w_pulse_rise) begin
              r_shift <= {1'b0, r_shift[7:1]};
              if (bit_idx == 4'd7) begin
                r_state  <= TAIL;
                data_out <= TAIL_LEVEL;
                bit_idx  <= 4'd8;
              end else begin
                data_out <= enc(r_shift[1]);
                bit_idx  <= bit_idx + 4'd1;
              end
            end
          end
          TAIL: begin
            data_out <= TAIL_LEVEL;
            bit_idx  <= 4'd8;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_n8_pad_responder.sv
// Directed bench for n8_pad_responder: table-driven frame vectors plus latency/abort/reset sequences.
module tb_n8_pad_responder;

  logic       clk = 1'b0;
  logic       reset, latch_in, pulse_in;
  logic [7:0] buttons;
  logic       data_out, frame_done;
  logic [3:0] bit_idx;

  int checks   = 0;
  int failures = 0;
  int fd_count = 0;

  typedef struct {
    logic       latch;
    logic       pulse;
    int         cycles;
    logic       exp_data;
    logic [3:0] exp_idx;
  } vec_t;

  vec_t vecs[$];

  n8_pad_responder #(
    .ACTIVE_LOW  (1),
    .TAIL_LEVEL  (1'b1),
    .TURBO_FRAMES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .latch_in  (latch_in),
    .pulse_in  (pulse_in),
    .buttons   (buttons),
    .data_out  (data_out),
    .bit_idx   (bit_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_count++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic d, input logic [3:0] idx);
    chk({name, ".data_out"}, {7'd0, data_out}, {7'd0, d});
    chk({name, ".bit_idx"}, {4'd0, bit_idx}, {4'd0, idx});
  endtask

  task automatic pulse_once();
    pulse_in = 1'b1; step(6);
    pulse_in = 1'b0; step(6);
  endtask

  logic [7:0] btn;
  logic       d;
  logic [7:0] turbo_exp;

  initial begin
    reset = 1'b1; latch_in = 1'b0; pulse_in = 1'b0; buttons = 8'h00;
    step(2);
    reset = 1'b0;
    chk_out("reset", 1'b1, 4'd0);
    chk("reset.frame_done", {7'd0, frame_done}, 8'd0);

    for (int i = 0; i < 6; i++) begin
      pulse_in = ~pulse_in;
      step($urandom_range(4, 8));
      chk_out("idle_pulse", 1'b1, 4'd0);
    end
    pulse_in = 1'b0;
    step(6);
    chk("idle.frame_done_count", fd_count[7:0], 8'd0);

`ifdef N8_RESP_TURBO_EN
    // A held with select: A alternates every 2 frames, select always reads pressed.
    turbo_exp = 8'b0011_0011;
    buttons   = 8'b0000_0101;
    for (int f = 0; f < 8; f++) begin
      latch_in = 1'b1; step(6);
      latch_in = 1'b0; step(6);
      chk($sformatf("turbo_A_f%0d", f), {7'd0, data_out}, {7'd0, turbo_exp[f]});
      pulse_once();
      pulse_once();
      chk($sformatf("turbo_sel_f%0d", f), {7'd0, data_out}, 8'd0);
    end
`else
    // Full frame from the table, then 4 extra pulses past the tail.
    btn     = 8'b0000_0101;
    buttons = btn;
    vecs.push_back('{1'b1, 1'b0, 6, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 1'b0, 6, 1'b0, 4'd0});
    for (int i = 1; i <= 8; i++) begin
      d = (i == 8) ? 1'b1 : ~btn[i];
      vecs.push_back('{1'b0, 1'b1, 6, d, 4'(i)});
      vecs.push_back('{1'b0, 1'b0, 6, d, 4'(i)});
    end
    for (int i = 0; i < 4; i++) begin
      vecs.push_back('{1'b0, 1'b1, 6, 1'b1, 4'd8});
      vecs.push_back('{1'b0, 1'b0, 6, 1'b1, 4'd8});
    end
    fd_count = 0;
    foreach (vecs[i]) begin
      latch_in = vecs[i].latch;
      pulse_in = vecs[i].pulse;
      step(vecs[i].cycles);
      chk_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_idx);
    end
    chk("frame.frame_done_count", fd_count[7:0], 8'd1);

    // Abort after 3 pulses: exact 3-edge latency to reload.
    latch_in = 1'b1; step(6);
    latch_in = 1'b0; step(6);
    pulse_once(); pulse_once(); pulse_once();
    chk_out("abort.before", 1'b1, 4'd3);
    buttons  = 8'b1010_0001;
    latch_in = 1'b1;
    step(2);
    chk_out("abort.edge2", 1'b1, 4'd3);
    step(1);
    chk_out("abort.edge3", 1'b0, 4'd0);
    step(3);

    // frame_done is exactly one cycle, 3 edges after the latch fall.
    latch_in = 1'b0;
    step(2);
    chk("fd.edge2", {7'd0, frame_done}, 8'd0);
    step(1);
    chk("fd.edge3", {7'd0, frame_done}, 8'd1);
    step(1);
    chk("fd.edge4", {7'd0, frame_done}, 8'd0);
    step(2);
    pulse_once();
    chk_out("shift1", 1'b1, 4'd1);

    // Latch and pulse rise together: latch wins, no shift.
    latch_in = 1'b1; pulse_in = 1'b1;
    step(3);
    chk_out("same_edge", 1'b0, 4'd0);
    step(3);
    chk_out("same_edge.hold", 1'b0, 4'd0);
    pulse_in = 1'b0; latch_in = 1'b0; step(6);
    chk_out("same_edge.shift0", 1'b0, 4'd0);

    // Mid-frame reset at bit 5 with latch held high through and after reset.
    for (int i = 0; i < 5; i++) pulse_once();
    chk_out("mid.bit5", 1'b0, 4'd5);
    reset = 1'b1; latch_in = 1'b1;
    step(1);
    chk_out("mid.reset", 1'b1, 4'd0);
    step(1);
    reset = 1'b0;
    step(2);
    chk_out("mid.post2", 1'b1, 4'd0);
    step(1);
    chk_out("mid.post3", 1'b0, 4'd0);
    latch_in = 1'b0; step(6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
